// File: rtl/falcon_clk_pkg.sv
// rtl/falcon_clk_pkg.sv - shared types and default timing constants for the clock/reset sequencer
package falcon_clk_pkg;

    typedef enum logic [2:0] {
        PLL_RESET,
        WAIT_LOCK,
        STABLE,
        REL_MEM,
        REL_PERIPH,
        REL_CPU,
        RUN
    } seq_state_t;

    localparam int DEF_PLL_RST_CYCLES = 4;
    localparam int DEF_LOCK_TIMEOUT   = 1000;
    localparam int DEF_STABLE_CYCLES  = 64;
    localparam int DEF_STAGE_DELAY    = 16;

    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/sync2.sv
// rtl/sync2.sv - generic two-flop single-bit synchroniser
module sync2 (
    input  logic clock,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clock) begin
        if (reset) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_reset_sequencer.sv
// rtl/pll_reset_sequencer.sv - PLL reset/lock qualification and staged core reset release
module pll_reset_sequencer
    import falcon_clk_pkg::*;
#(
    parameter int PLL_RST_CYCLES = DEF_PLL_RST_CYCLES,
    parameter int LOCK_TIMEOUT   = DEF_LOCK_TIMEOUT,
    parameter int STABLE_CYCLES  = DEF_STABLE_CYCLES,
    parameter int STAGE_DELAY    = DEF_STAGE_DELAY
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       pll_locked,
    input  logic       sw_reset_req,
    output logic       pll_rst,
    output logic       mem_reset,
    output logic       periph_reset,
    output logic       cpu_reset,
    output logic       ready,
    output logic [7:0] retry_count,
    output logic [7:0] lock_lost_count
);

    localparam int MAX_P = max4(PLL_RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES, STAGE_DELAY);
    localparam int TW    = $clog2(MAX_P) + 1;

    localparam logic [TW-1:0] LD_PLL    = TW'(PLL_RST_CYCLES - 1);
    localparam logic [TW-1:0] LD_LOCK   = TW'(LOCK_TIMEOUT - 1);
    localparam logic [TW-1:0] LD_STABLE = TW'(STABLE_CYCLES - 1);
    localparam logic [TW-1:0] LD_STAGE  = TW'(STAGE_DELAY - 1);

    seq_state_t    state, state_nxt;
    logic [TW-1:0] timer, timer_nxt;
    logic          lk;
    logic          timer_done;
    logic          retry_inc, lost_inc;

    sync2 u_lock_sync (
        .clock (clock),
        .reset (reset),
        .d     (pll_locked),
        .q     (lk)
    );

    assign timer_done = (timer == '0);

    always_comb begin
        state_nxt = state;
        retry_inc = 1'b0;
        lost_inc  = 1'b0;
        case (state)
            PLL_RESET: if (timer_done) state_nxt = WAIT_LOCK;
            WAIT_LOCK: begin
                if (lk) begin
                    state_nxt = STABLE;
                end else if (timer_done) begin
                    state_nxt = PLL_RESET;
                    retry_inc = 1'b1;
                end
            end
            STABLE, REL_MEM, REL_PERIPH, REL_CPU, RUN: begin
                // Loss of lock outranks every other transition, including a software request.
                if (!lk) begin
                    state_nxt = PLL_RESET;
                    lost_inc  = 1'b1;
                end else begin
                    case (state)
                        STABLE:     if (timer_done) state_nxt = REL_MEM;
                        REL_MEM:    if (timer_done) state_nxt = REL_PERIPH;
                        REL_PERIPH: if (timer_done) state_nxt = REL_CPU;
                        REL_CPU:    if (timer_done) state_nxt = RUN;
                        default:    if (sw_reset_req) state_nxt = STABLE;
                    endcase
                end
            end
            default: state_nxt = PLL_RESET;
        endcase

        timer_nxt = timer;
        if (state_nxt != state) begin
            case (state_nxt)
                PLL_RESET: timer_nxt = LD_PLL;
                WAIT_LOCK: timer_nxt = LD_LOCK;
                STABLE:    timer_nxt = LD_STABLE;
                default:   timer_nxt = LD_STAGE;
            endcase
        end else if (!timer_done) begin
            timer_nxt = timer - 1'b1;
        end
    end

    // Reset is treated as an entry into PLL_RESET, so the timer starts with its hold count.
    always_ff @(posedge clock) begin
        if (reset) begin
            state           <= PLL_RESET;
            timer           <= LD_PLL;
            pll_rst         <= 1'b1;
            mem_reset       <= 1'b1;
            periph_reset    <= 1'b1;
            cpu_reset       <= 1'b1;
            ready           <= 1'b0;
            retry_count     <= '0;
            lock_lost_count <= '0;
        end else begin
            state        <= state_nxt;
            timer        <= timer_nxt;
            pll_rst      <= (state_nxt == PLL_RESET);
            mem_reset    <= !(state_nxt inside {REL_MEM, REL_PERIPH, REL_CPU, RUN});
            periph_reset <= !(state_nxt inside {REL_PERIPH, REL_CPU, RUN});
            cpu_reset    <= !(state_nxt inside {REL_CPU, RUN});
            ready        <= (state_nxt == RUN);
            if (retry_inc && retry_count != 8'hFF)
                retry_count <= retry_count + 8'd1;
            if (lost_inc && lock_lost_count != 8'hFF)
                lock_lost_count <= lock_lost_count + 8'd1;
        end
    end

endmodule
